// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the debounce bank.
package debounce_pkg;

  localparam int unsigned DB_NCH        = 4;
  localparam int unsigned DB_CNT_W      = 22;
  localparam int unsigned DB_STABLE_CNT = 2000000;

  // Bits needed to hold the counter ceiling STABLE_CNT-1.
  function automatic int unsigned cnt_width_for(input int unsigned stable_cnt);
    if (stable_cnt <= 2) begin
      return 1;
    end
    return $clog2(stable_cnt);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchroniser, stability counter, level register
// and registered rise/fall pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W      = DB_CNT_W,
  parameter int unsigned STABLE_CNT = DB_STABLE_CNT,
  parameter logic        INIT_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_next,
  output logic fall_next
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CNT - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, fall_q;
  logic             mismatch;

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    rise_next = 1'b0;
    fall_next = 1'b0;
    mismatch  = sync_q[1] ^ level_q;
    if (!mismatch) begin
      cnt_d = '0;
    end else if (sample_en) begin
      // Ceiling compare: the counter never counts past STABLE_CNT-1.
      if (cnt_q >= CntLast) begin
        level_d   = sync_q[1];
        cnt_d     = '0;
        rise_next = sync_q[1];
        fall_next = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= {2{INIT_LEVEL}};
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_next;
      fall_q  <= fall_next;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of NCH independent debounce channels with a shared any_change flag.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned NCH        = DB_NCH,
  parameter int unsigned CNT_W      = DB_CNT_W,
  parameter int unsigned STABLE_CNT = DB_STABLE_CNT,
  parameter logic        INIT_LEVEL = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sample_en,
  input  logic [NCH-1:0] signal,
  output logic [NCH-1:0] debounced_signal,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic           any_change
);

  logic [NCH-1:0] rise_next, fall_next;
  logic           any_change_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W      (CNT_W),
      .STABLE_CNT (STABLE_CNT),
      .INIT_LEVEL (INIT_LEVEL)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .sample_en (sample_en),
      .raw       (signal[i]),
      .level     (debounced_signal[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .rise_next (rise_next[i]),
      .fall_next (fall_next[i])
    );
  end

  // Registered from the channels' next-state pulses so it lines up with rise/fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= |(rise_next | fall_next);
    end
  end

  assign any_change = any_change_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank (NCH=4, CNT_W=4, STABLE_CNT=4).
module tb_debounce_bank;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 4;
  localparam int unsigned SC  = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           sample_en = 1'b1;
  logic [NCH-1:0] sig = '0;
  logic [NCH-1:0] dbg, rise, fall;
  logic           any_change;

  int n_checks = 0;
  int n_pass   = 0;

  typedef logic [12:0] exp_t;
  exp_t sb[$];

  debounce_bank #(
    .NCH        (NCH),
    .CNT_W      (CW),
    .STABLE_CNT (SC),
    .INIT_LEVEL (1'b0)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .sample_en        (sample_en),
    .signal           (sig),
    .debounced_signal (dbg),
    .rise             (rise),
    .fall             (fall),
    .any_change       (any_change)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model built from the behavioural rules, one expectation per event.
  logic [NCH-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_rise = '0, m_fall = '0;
  logic           m_any = 1'b0;
  int             m_cnt[NCH];

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        sb.delete();
      end else begin
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < NCH; i++) begin
          if (m_s2[i] == m_lvl[i]) begin
            m_cnt[i] = 0;
          end else if (sample_en) begin
            if (m_cnt[i] == SC - 1) begin
              m_lvl[i]  = m_s2[i];
              m_cnt[i]  = 0;
              m_rise[i] = m_s2[i];
              m_fall[i] = ~m_s2[i];
            end else begin
              m_cnt[i]++;
            end
          end
        end
        m_any = |(m_rise | m_fall);
        m_s2  = m_s1;
        m_s1  = sig;
      end
      sb.push_back({m_lvl, m_rise, m_fall, m_any});
    end
  end

  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check("outputs", {19'd0, dbg, rise, fall, any_change}, {19'd0, e});
      end
    end
  end

  task automatic pulse_ch1(input int hi, output int nr, output int nf);
    nr = 0;
    nf = 0;
    sig[1] = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      nr += int'(rise[1]);
      nf += int'(fall[1]);
      if (k == hi - 1) sig[1] = 1'b0;
    end
  endtask

  initial begin
    int nr, nf, maxc, c;
    bit seen;

    #1;
    check("reset_state", {19'd0, dbg, rise, fall, any_change}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Clean step on channel 0: change on the 6th edge after the step.
    sig[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) check("lat_before", {31'd0, dbg[0]}, 32'd0);
      if (k == 6) begin
        check("lat_level", {31'd0, dbg[0]}, 32'd1);
        check("lat_rise", {31'd0, rise[0]}, 32'd1);
        check("lat_any", {31'd0, any_change}, 32'd1);
      end
      if (k == 7) check("lat_rise_drop", {31'd0, rise[0]}, 32'd0);
    end
    @(negedge clk);

    // Glitch one short of the threshold, then exactly at it.
    pulse_ch1(3, nr, nf);
    check("short_rise", nr, 0);
    check("short_fall", nf, 0);
    pulse_ch1(4, nr, nf);
    check("full_rise", nr, 1);
    check("full_fall", nf, 1);

    // Chatter: level lasts one clock, so the counter never gets past 1.
    maxc = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      sig[2] = ~sig[2];
      c = int'(dut.g_ch[2].u_ch.cnt_q);
      if (c > maxc) maxc = c;
    end
    repeat (4) @(negedge clk);
    check("chatter_level", {31'd0, dbg[2]}, 32'd0);
    check("chatter_maxcnt", (maxc <= 1) ? 32'd1 : 32'd0, 32'd1);

    // Strobed sampling on channel 3: gaps hold the count.
    seen = 1'b0;
    sig[3] = 1'b1;
    for (int k = 0; k < 60 && !seen; k++) begin
      sample_en = (k % 3 == 0);
      @(negedge clk);
      if (dbg[3]) seen = 1'b1;
    end
    sample_en = 1'b1;
    check("strobe_change", {31'd0, seen}, 32'd1);

    // All channels step together.
    sig = '0;
    repeat (12) @(negedge clk);
    sig = 4'hF;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (rise != '0) begin
        seen = 1'b1;
        check("all_rise", {28'd0, rise}, 32'hF);
        check("all_any", {31'd0, any_change}, 32'd1);
        @(posedge clk);
        #1;
        check("all_any_drop", {31'd0, any_change}, 32'd0);
        check("all_rise_drop", {28'd0, rise}, 32'd0);
      end
    end
    check("all_rise_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);

    // Async reset mid-count aborts the count.
    sig = '0;
    repeat (12) @(negedge clk);
    sig[0] = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_out", {19'd0, dbg, rise, fall, any_change}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check("rel_no_pulse", {27'd0, rise, any_change}, 32'd0);
      if (k == 5) check("rel_before", {31'd0, dbg[0]}, 32'd0);
      if (k == 6) check("rel_level", {31'd0, dbg[0]}, 32'd1);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
